// File: rtl/vector_load_sequencer_pkg.sv
// vector_load_sequencer_pkg: VL encodings, opcode and FSM states shared by the vector load engine.
package vector_load_sequencer_pkg;
  localparam logic [1:0] VL_1   = 2'b00;
  localparam logic [1:0] VL_2   = 2'b01;
  localparam logic [1:0] VL_4   = 2'b10;
  localparam logic [1:0] VL_ILL = 2'b11;
  localparam logic [6:0] VECLOAD_OPCODE = 7'b0000010;
  typedef enum logic [1:0] {IDLE, REQ, WAIT} state_e;
  function automatic logic [1:0] vl_last(input logic [1:0] vl);
    return vl == VL_4 ? 2'd3 : vl == VL_2 ? 2'd1 : 2'd0;
  endfunction
endpackage

// File: rtl/vector_load_sequencer.sv
// vector_load_sequencer: issues one read per vector element and writes each result into WVR/SVR,
// stalling the pipeline until the last element lands.
module vector_load_sequencer
  import vector_load_sequencer_pkg::*;
#(
  parameter int XLEN       = 32,
  parameter int ADDR_W     = 32,
  parameter int VREG_AW    = 5,
  parameter int ELEM_BYTES = 4
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               start_wvr,
  input  logic               start_svr,
  input  logic [1:0]         vl,
  input  logic [ADDR_W-1:0]  base_addr,
  input  logic [VREG_AW-1:0] vd,
  output logic               mem_req,
  output logic [ADDR_W-1:0]  mem_addr,
  input  logic               mem_gnt,
  input  logic               mem_rvalid,
  input  logic [XLEN-1:0]    mem_rdata,
  input  logic               mem_err,
  output logic               vr_we,
  output logic               vr_sel_wide,
  output logic [VREG_AW-1:0] vr_addr,
  output logic [1:0]         vr_elem,
  output logic [XLEN-1:0]    vr_wdata,
  output logic               stall,
  output logic               busy,
  output logic               err
);
  state_e state_q, state_d;
  logic [ADDR_W-1:0] base_q, base_d;
  logic [VREG_AW-1:0] vd_q, vd_d, vr_addr_q, vr_addr_d;
  logic [1:0] idx_q, idx_d, last_q, last_d, vr_elem_q, vr_elem_d;
  logic [XLEN-1:0] vr_wdata_q, vr_wdata_d;
  logic wide_q, wide_d, vr_we_q, vr_we_d, vr_sel_wide_q, vr_sel_wide_d, err_q, err_d;
  always_comb begin
    state_d       = state_q;
    base_d        = base_q;
    vd_d          = vd_q;
    wide_d        = wide_q;
    idx_d         = idx_q;
    last_d        = last_q;
    vr_we_d       = 1'b0;
    vr_sel_wide_d = vr_sel_wide_q;
    vr_addr_d     = vr_addr_q;
    vr_elem_d     = vr_elem_q;
    vr_wdata_d    = vr_wdata_q;
    err_d         = 1'b0;
    case (state_q)
      IDLE: if (start_wvr | start_svr) begin
        if (vl == VL_ILL) err_d = 1'b1;
        else begin
          base_d  = base_addr;
          vd_d    = vd;
          wide_d  = start_wvr;
          last_d  = vl_last(vl);
          idx_d   = 2'd0;
          state_d = REQ;
        end
      end
      REQ: state_d = mem_gnt ? WAIT : REQ;
      WAIT: if (mem_rvalid) begin
        if (mem_err) begin
          err_d   = 1'b1;
          state_d = IDLE;
        end else begin
          vr_we_d       = 1'b1;
          vr_sel_wide_d = wide_q;
          vr_addr_d     = vd_q;
          vr_elem_d     = idx_q;
          vr_wdata_d    = mem_rdata;
          idx_d         = idx_q == last_q ? idx_q : idx_q + 2'd1;
          state_d       = idx_q == last_q ? IDLE : REQ;
        end
      end
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q       <= IDLE;
      base_q        <= '0;
      vd_q          <= '0;
      wide_q        <= 1'b0;
      idx_q         <= '0;
      last_q        <= '0;
      vr_we_q       <= 1'b0;
      vr_sel_wide_q <= 1'b0;
      vr_addr_q     <= '0;
      vr_elem_q     <= '0;
      vr_wdata_q    <= '0;
      err_q         <= 1'b0;
    end else begin
      state_q       <= state_d;
      base_q        <= base_d;
      vd_q          <= vd_d;
      wide_q        <= wide_d;
      idx_q         <= idx_d;
      last_q        <= last_d;
      vr_we_q       <= vr_we_d;
      vr_sel_wide_q <= vr_sel_wide_d;
      vr_addr_q     <= vr_addr_d;
      vr_elem_q     <= vr_elem_d;
      vr_wdata_q    <= vr_wdata_d;
      err_q         <= err_d;
    end
  end
  // address wraps modulo 2^ADDR_W by truncation
  assign mem_addr    = base_q + ADDR_W'(idx_q) * ADDR_W'(ELEM_BYTES);
  assign mem_req     = state_q == REQ;
  assign stall       = state_q != IDLE;
  assign busy        = stall;
  assign vr_we       = vr_we_q;
  assign vr_sel_wide = vr_sel_wide_q;
  assign vr_addr     = vr_addr_q;
  assign vr_elem     = vr_elem_q;
  assign vr_wdata    = vr_wdata_q;
  assign err         = err_q;
endmodule
